// File: rtl/onehot_pulse_decoder_if.sv
// rtl/onehot_pulse_decoder_if.sv - code/length input stream for the one-hot pulse decoder
interface onehot_pulse_decoder_if #(
  parameter int LEN_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       d;
  logic [LEN_W-1:0] len;

  modport master (output in_valid, d, len, input in_ready);
  modport slave  (input in_valid, d, len, output in_ready);
endinterface

// File: rtl/onehot_pulse_decoder.sv
// rtl/onehot_pulse_decoder.sv - FIFO-buffered 3-to-8 decoder emitting timed one-hot pulses
// Optional macro DECODER_GAP_EN inserts a one-cycle all-zero gap between consecutive pulses.
module onehot_pulse_decoder #(
  parameter  int DEPTH = 4,
  parameter  int LEN_W = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onehot_pulse_decoder_if.slave s_if,
  output logic [7:0]            y,
  output logic                  busy,
  output logic [CNT_W-1:0]      count
);

`ifdef DECODER_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1} state_t;
`endif

  state_t           r_state;
  logic [7:0]       r_y;
  logic             r_busy;
  logic [LEN_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [2:0]       r_mem_d   [DEPTH];
  logic [LEN_W-1:0] r_mem_len [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_active_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [2:0]       w_head_d;
  logic [LEN_W-1:0] w_head_len;
  logic [LEN_W-1:0] w_load_cnt;
  logic [7:0]       w_head_onehot;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == CNT_W'(DEPTH));
  assign s_if.in_ready = !w_full;
  assign w_push        = s_if.in_valid && !w_full;
  assign w_head_d      = r_mem_d[r_rptr];
  assign w_head_len    = r_mem_len[r_rptr];
  // A zero length still produces a single-cycle pulse.
  assign w_load_cnt    = (w_head_len == '0) ? '0 : w_head_len - LEN_W'(1);
  assign w_head_onehot = 8'b1 << w_head_d;

  always_comb begin
    w_pop = 1'b0;
    if (!w_empty) begin
      case (r_state)
        IDLE:  w_pop = 1'b1;
        PULSE: begin
`ifdef DECODER_GAP_EN
          w_pop = 1'b0;
`else
          w_pop = (r_cnt == '0);
`endif
        end
`ifdef DECODER_GAP_EN
        GAP:   w_pop = 1'b1;
`endif
        default: w_pop = 1'b0;
      endcase
    end
  end

`ifdef DECODER_GAP_EN
  assign w_active_nxt = w_pop || (r_state == PULSE);
`else
  assign w_active_nxt = w_pop || ((r_state == PULSE) && (r_cnt != '0));
`endif

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_d[r_wptr]   <= s_if.d;
      r_mem_len[r_wptr] <= s_if.len;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_y     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= w_active_nxt || (w_count_nxt != '0);
      if (w_pop) begin
        r_state <= PULSE;
        r_y     <= w_head_onehot;
        r_cnt   <= w_load_cnt;
      end else begin
        case (r_state)
          PULSE: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - LEN_W'(1);
            end else begin
              r_y <= '0;
`ifdef DECODER_GAP_EN
              r_state <= GAP;
`else
              r_state <= IDLE;
`endif
            end
          end
          default: begin
            r_y     <= '0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign y     = r_y;
  assign busy  = r_busy;
  assign count = r_count;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb/tb_onehot_pulse_decoder.sv - self-checking bench for onehot_pulse_decoder
module tb_onehot_pulse_decoder;
  localparam int DEPTH = 4;
  localparam int LEN_W = 4;
`ifdef DECODER_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] y;
  logic       busy;
  logic [2:0] count;

  onehot_pulse_decoder_if #(.LEN_W(LEN_W)) bif ();

  onehot_pulse_decoder #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (bif.slave),
    .y     (y),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] d;
    logic [3:0] len;
    logic [7:0] exp_y;
    int         exp_cyc;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int t = 0;
  bit last_acc = 1'b0;

  // Reference: each accepted code becomes a pulse window [start, start+L-1],
  // starting at the later of (accept+1) and the end of the previous window (+gap).
  int m_acc[$];
  int m_st[$];
  int m_ln[$];
  int m_d[$];
  int m_next = 0;

  function automatic void model_reset();
    m_acc.delete(); m_st.delete(); m_ln.delete(); m_d.delete();
    m_next = 0;
  endfunction

  function automatic void model_push(input int tt, input int dd, input int ll);
    int l;
    int s;
    l = (ll == 0) ? 1 : ll;
    s = (tt + 1 > m_next) ? tt + 1 : m_next;
    m_acc.push_back(tt); m_st.push_back(s); m_ln.push_back(l); m_d.push_back(dd);
    m_next = s + l + GAP;
  endfunction

  function automatic int occ(input int tt);
    int n = 0;
    foreach (m_acc[i]) if (m_acc[i] <= tt && m_st[i] > tt) n++;
    return n;
  endfunction

  function automatic logic [7:0] exp_y(input int tt);
    logic [7:0] r = '0;
    foreach (m_st[i]) if (tt >= m_st[i] && tt < m_st[i] + m_ln[i]) r[m_d[i]] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_busy(input int tt);
    logic b = (occ(tt) > 0);
    foreach (m_st[i]) if (tt >= m_st[i] && tt < m_st[i] + m_ln[i] + GAP) b = 1'b1;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0d: actual=%0h required=%0h", nm, t, act, exp);
    end
  endtask

  task automatic drive(input bit v, input int dd, input int ll);
    bif.in_valid = v;
    bif.d        = 3'(dd);
    bif.len      = LEN_W'(ll);
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    logic er;
    int   dd;
    int   ll;
    er = (occ(t) < DEPTH);
    chk("in_ready", 32'(bif.in_ready), 32'(er));
    last_acc = bif.in_valid && er;
    dd = int'(bif.d);
    ll = int'(bif.len);
    @(posedge clk);
    t++;
    if (last_acc) model_push(t, dd, ll);
    @(negedge clk);
    chk("y", 32'(y), 32'(exp_y(t)));
    chk("count", 32'(count), 32'(occ(t)));
    chk("busy", 32'(busy), 32'(exp_busy(t)));
    chk("onehot", 32'($countones(y) <= 1), 32'(1));
  endtask

  task automatic burst(input int ln, input int nt, input bit expect_full);
    int         idx = 0;
    int         seen_full = 0;
    int         run = 0;
    int         l;
    logic [7:0] cur = '0;
    logic [7:0] yq[$];
    logic [7:0] rv[$];
    int         rl[$];
    l = (ln == 0) ? 1 : ln;
    for (int c = 0; c < nt; c++) begin
      if (idx < 8) drive(1'b1, idx, ln);
      else         drive(1'b0, 0, 0);
      if (bif.in_ready === 1'b0) seen_full++;
      tick();
      if (last_acc) idx++;
      yq.push_back(y);
    end
    foreach (yq[i]) begin
      if (yq[i] != cur) begin
        if (cur != '0) begin rv.push_back(cur); rl.push_back(run); end
        cur = yq[i];
        run = 1;
      end else begin
        run++;
      end
    end
    if (cur != '0) begin rv.push_back(cur); rl.push_back(run); end
    chk("burst_accepted", 32'(idx), 32'(8));
    chk("burst_runs", 32'(rv.size()), 32'(8));
    for (int k = 0; k < 8 && k < rv.size(); k++) begin
      chk("burst_code", 32'(rv[k]), 32'(1) << k);
      chk("burst_len", 32'(rl[k]), 32'(l));
    end
    if (expect_full) chk("fifo_full_seen", 32'(seen_full != 0), 32'(1));
  endtask

  initial begin
    vec_t       vt[6];
    logic [7:0] b2b[5];

    vt[0] = '{3'd5, 4'd3,  8'h20, 3};
    vt[1] = '{3'd0, 4'd0,  8'h01, 1};
    vt[2] = '{3'd7, 4'd15, 8'h80, 15};
    vt[3] = '{3'd3, 4'd1,  8'h08, 1};
    vt[4] = '{3'd6, 4'd2,  8'h40, 2};
    vt[5] = '{3'd1, 4'd8,  8'h02, 8};
    if (GAP != 0) b2b = '{8'h80, 8'h80, 8'h00, 8'h80, 8'h80};
    else          b2b = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00};

    drive(1'b0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_y", 32'(y), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_in_ready", 32'(bif.in_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(1'b1, int'(vt[i].d), int'(vt[i].len));
      tick();
      drive(1'b0, 0, 0);
      for (int c = 1; c <= vt[i].exp_cyc + 1; c++) begin
        tick();
        chk("vec_y", 32'(y), (c <= vt[i].exp_cyc) ? 32'(vt[i].exp_y) : 32'(0));
      end
      repeat (2) tick();
      chk("vec_busy_end", 32'(busy), 32'(0));
    end

    drive(1'b1, 7, 2);
    tick();
    tick();
    drive(1'b0, 0, 0);
    chk("b2b_y", 32'(y), 32'(b2b[0]));
    for (int j = 1; j < 5; j++) begin
      tick();
      chk("b2b_y", 32'(y), 32'(b2b[j]));
    end
    repeat (4) tick();

    burst(15, 170, 1'b1);
    burst(1, 40, 1'b0);

    drive(1'b1, 5, 10); tick();
    drive(1'b1, 2, 3);  tick();
    drive(1'b1, 4, 3);  tick();
    drive(1'b0, 0, 0);  tick();
    chk("pre_rst_y", 32'(y), 32'(8'h20));
    chk("pre_rst_count", 32'(count), 32'(2));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_y", 32'(y), 32'(0));
    chk("midrst_count", 32'(count), 32'(0));
    chk("midrst_in_ready", 32'(bif.in_ready), 32'(1));
    chk("midrst_busy", 32'(busy), 32'(0));
    @(posedge clk);
    t++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) tick();

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 7),
            ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
      tick();
    end
    drive(1'b0, 0, 0);
    repeat (90) tick();
    chk("final_busy", 32'(busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
